mips_fetch: RTL and testbench

Instruction-fetch stage for the single-cycle-issue MIPS datapath; it directly feeds the instruction decoder. It holds the PC and issues word reads to instruction memory over a variable-latency req/ack handshake. It presents one instruction at a time to decode/execute, then computes the next PC from the 2-bit `control_type` (00 fallthrough, 01 branch target, 10 jump target, 11 jump register) returned when that instruction is consumed.

---
 rtl/mips_fetch_pkg.sv | 35 +++
 rtl/mips_fetch_next_pc.sv | 37 +++
 rtl/mips_fetch.sv | 92 +++++++++
 tb/tb_mips_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: control-type and opcode
// encodings, fetch FSM states and the default reset PC.
package mips_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

   // Next-PC select returned by decode/execute with each consumed instruction
   typedef enum logic [1:0] {
      CT_FALL   = 2'b00,
      CT_BRANCH = 2'b01,
      CT_JUMP   = 2'b10,
      CT_JR     = 2'b11
   } ctrl_type_t;

   typedef enum logic [1:0] {
      ST_REQ   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_HOLD  = 2'b10,
      ST_FAULT = 2'b11
   } fetch_state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_fetch_next_pc.sv
// Combinational next-PC selection for the instruction being consumed.
// JR targets are returned word-aligned; misaligned flags nonzero low bits.
module fetch_next_pc
   import mips_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   input  logic [1:0]  control_type,
   input  logic [31:0] rs_data,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] pc4;
   logic [31:0] branch_off;
   logic [5:0]  unused_opcode;

   assign pc4           = pc + 32'd4;
   assign branch_off    = {{14{inst[15]}}, inst[15:0], 2'b00};
   assign unused_opcode = inst[31:26];

   always_comb begin
      next_pc    = pc4;
      misaligned = 1'b0;
      case (ctrl_type_t'(control_type))
         CT_FALL:   next_pc = pc4;
         CT_BRANCH: next_pc = pc4 + branch_off;
         CT_JUMP:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
         CT_JR: begin
            next_pc    = word_align(rs_data);
            misaligned = (rs_data[1:0] != 2'b00);
         end
         default:   next_pc = pc4;
      endcase
   end

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch stage: PC register, imem req/ack handshake, one-deep
// instruction hold. Optional FETCH_ALIGN_CHECK_EN traps misaligned JR targets.
module mips_fetch
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [1:0]  control_type,
   input  logic [31:0] rs_data,
   output logic        fetch_except
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  next_pc;
   logic         misaligned;

   fetch_next_pc u_next_pc (
      .pc           (pc),
      .inst         (inst),
      .control_type (control_type),
      .rs_data      (rs_data),
      .next_pc      (next_pc),
      .misaligned   (misaligned)
   );

   // Request is gated by reset so memory sees it drop while reset is held
   // and sees the REQ-state request in the very first cycle after release.
   assign imem_req  = reset && (state == ST_REQ || state == ST_WAIT);
   assign imem_addr = imem_req ? word_align(pc) : 32'h0;

`ifndef FETCH_ALIGN_CHECK_EN
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
   assign fetch_except      = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_except <= 1'b0;
`endif
      end else begin
         case (state)
            ST_REQ: state <= ST_WAIT;
            ST_WAIT: begin
               if (imem_ack) begin
                  inst       <= imem_rdata;
                  inst_pc    <= pc;
                  inst_valid <= 1'b1;
                  state      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                  if (misaligned) begin
                     fetch_except <= 1'b1;
                     state        <= ST_FAULT;
                  end else begin
                     pc    <= next_pc;
                     state <= ST_REQ;
                  end
`else
                  pc    <= next_pc;
                  state <= ST_REQ;
`endif
               end
            end
            // FAULT is sticky until reset
            default: state <= ST_FAULT;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_fetch.sv
// Scoreboard bench for mips_fetch: random memory latency, stray acks/readies,
// directed branch/jump/JR/wrap steps, then reset-during-WAIT.
module tb_mips_fetch;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int LAST = 60;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_t;

   typedef struct {
      int          delay;
      logic [1:0]  ct;
      logic [31:0] rs;
      bit          poke;
      logic [31:0] poke_addr;
      logic [31:0] poke_data;
   } step_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [1:0]  control_type;
   logic [31:0] rs_data;
   logic        fetch_except;

   logic        mem_run, resp_ack, man_ack;
   logic [31:0] resp_rdata, man_rdata;
   assign imem_ack   = mem_run ? resp_ack : man_ack;
   assign imem_rdata = mem_run ? resp_rdata : man_rdata;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_addr_q[$];
   fetch_t      exp_inst_q[$];
   step_t       dir_q[$];
   int          lat_q[$];
   int          checks = 0, errors = 0, consumed = 0;
   bit          run = 0, mon_en = 0, ack_fire = 0, fault_expected = 0;
   logic [31:0] model_pc, model_word;

   mips_fetch #(.RESET_PC(RESET_PC)) dut (
      .clock        (clock),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .control_type (control_type),
      .rs_data      (rs_data),
      .fetch_except (fetch_except)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a ^ 32'h5A5A_0F0F) * 32'h9E37_79B1 + 32'h1234_5677;
   endfunction

   // Reference next-PC straight from the architectural rules
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                            input logic [1:0] ct, input logic [31:0] rs);
      logic [31:0] seq;
      int off;
      seq = pc + 32'd4;
      off = $signed(word[15:0]);
      case (ct)
         2'd0:    return seq;
         2'd1:    return seq + 32'(off * 4);
         2'd2:    return (seq & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
         default: return rs & ~32'd3;
      endcase
   endfunction

   task automatic push_fetch(input logic [31:0] a);
      fetch_t f;
      f.pc = a;
      f.word = mem_word(a);
      exp_addr_q.push_back(a);
      exp_inst_q.push_back(f);
      model_pc = a;
      model_word = f.word;
   endtask

   task automatic add_step(input int d, input logic [1:0] ct, input logic [31:0] rs,
                           input bit pk, input logic [31:0] pa, input logic [31:0] pd);
      step_t s;
      s.delay = d; s.ct = ct; s.rs = rs; s.poke = pk; s.poke_addr = pa; s.poke_data = pd;
      dir_q.push_back(s);
   endtask

   // Instruction memory: variable latency, plus stray acks while idle
   initial begin
      int cnt, lat;
      cnt = 0; lat = 0;
      resp_ack = 1'b0; resp_rdata = 32'h0;
      forever begin
         @(negedge clock);
         if (!mem_run) begin
            cnt = 0; resp_ack = 1'b0; ack_fire = 0;
            continue;
         end
         if (imem_req) begin
            cnt++;
            if (cnt == 1) lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(0, 3));
            resp_ack   = (cnt >= 2 + lat);
            resp_rdata = resp_ack ? mem_word(imem_addr) : $urandom;
         end else begin
            cnt = 0;
            resp_ack   = ($urandom_range(0, 3) == 0);
            resp_rdata = $urandom;
         end
         ack_fire = imem_req && resp_ack;
      end
   end

   // Consumer: stalls, picks control_type, updates the model on each consume
   initial begin
      step_t s;
      inst_ready = 1'b0; control_type = 2'd0; rs_data = 32'h0;
      forever begin
         @(negedge clock);
         if (!run) begin
            inst_ready = 1'b0;
            continue;
         end
         if (!inst_valid) begin
            inst_ready   = ($urandom_range(0, 3) == 0);
            control_type = 2'($urandom);
            rs_data      = $urandom;
            continue;
         end
         if (dir_q.size() > 0) s = dir_q.pop_front();
         else if (consumed == LAST)
            s = '{delay: 0, ct: 2'd3, rs: 32'h0040_0102, poke: 0, poke_addr: 32'h0, poke_data: 32'h0};
         else begin
            s.delay = $urandom_range(0, 2);
            s.ct    = 2'($urandom_range(0, 3));
            s.rs    = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            s.rs[1:0] = 2'b00;
`endif
            s.poke = 0;
         end
         inst_ready = 1'b0;
         repeat (s.delay) @(negedge clock);
         if (s.poke) mem[s.poke_addr] = s.poke_data;
         control_type = s.ct;
         rs_data      = s.rs;
         inst_ready   = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
         if (s.ct == 2'd3 && s.rs[1:0] != 2'b00) fault_expected = 1;
         else push_fetch(ref_next(model_pc, model_word, s.ct, s.rs));
`else
         push_fetch(ref_next(model_pc, model_word, s.ct, s.rs));
`endif
         consumed++;
         @(negedge clock);
         inst_ready = 1'b0;
      end
   end

   // Monitor: pops expected fetch addresses and instructions
   initial begin
      bit prev_req, prev_valid;
      fetch_t cur;
      logic [31:0] cur_addr;
      prev_req = 0; prev_valid = 0; cur_addr = 32'h0;
      cur.pc = 32'h0; cur.word = 32'h0;
      forever begin
         @(posedge clock);
         #1;
         if (!mon_en) begin
            prev_req = 0; prev_valid = 0;
            continue;
         end
         if (ack_fire) begin
            chk("capture_valid", {31'h0, inst_valid}, 32'h1);
            chk("capture_req_drop", {31'h0, imem_req}, 32'h0);
         end
         if (imem_req && !prev_req) begin
            if (exp_addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_req actual=%h expected=no request", imem_addr);
            end else begin
               cur_addr = exp_addr_q.pop_front();
               chk("fetch_addr", imem_addr, cur_addr);
            end
         end else if (imem_req) chk("addr_stable", imem_addr, cur_addr);
         if (inst_valid && !prev_valid) begin
            if (exp_inst_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid actual=%h expected=no instruction", inst_pc);
            end else cur = exp_inst_q.pop_front();
         end
         if (inst_valid) begin
            chk("inst", inst, cur.word);
            chk("inst_pc", inst_pc, cur.pc);
         end
         if (!fault_expected) chk("no_except", {31'h0, fetch_except}, 32'h0);
         prev_req = imem_req; prev_valid = inst_valid;
      end
   end

   initial begin
      reset = 1'b0; mem_run = 1'b0; man_ack = 1'b0; man_rdata = 32'h0;
      mem[RESET_PC]      = 32'h2008_0005;
      mem[32'h0040_0010] = 32'h1000_FFFE;
      mem[32'h1000_0000] = 32'h0800_0040;
      lat_q.push_back(0);
      lat_q.push_back(2);
      add_step(0, 2'd0, 32'h0, 0, 32'h0, 32'h0);                 // 400000 -> 400004
      add_step(2, 2'd0, 32'h0, 0, 32'h0, 32'h0);                 // 400004 -> 400008
      add_step(0, 2'd0, 32'h0, 0, 32'h0, 32'h0);                 // -> 40000C
      add_step(0, 2'd0, 32'h0, 0, 32'h0, 32'h0);                 // -> 400010
      add_step(1, 2'd1, 32'h0, 0, 32'h0, 32'h0);                 // branch -2 -> 40000C
      add_step(0, 2'd0, 32'h0, 1, 32'h0040_0010, 32'h1000_0003); // -> 400010
      add_step(0, 2'd1, 32'h0, 0, 32'h0, 32'h0);                 // branch +3 -> 400020
      add_step(0, 2'd3, 32'h1000_0000, 0, 32'h0, 32'h0);         // jr -> 10000000
      add_step(0, 2'd2, 32'h0, 0, 32'h0, 32'h0);                 // j -> 10000100
      add_step(1, 2'd3, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);         // jr -> FFFFFFFC
      add_step(0, 2'd0, 32'h0, 0, 32'h0, 32'h0);                 // wrap -> 0
      add_step(0, 2'd3, RESET_PC, 0, 32'h0, 32'h0);              // jr -> 400000

      repeat (3) @(negedge clock);
      #1;
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_except", {31'h0, fetch_except}, 32'h0);

      @(negedge clock);
      mem_run = 1'b1; run = 1; mon_en = 1;
      push_fetch(RESET_PC);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("first_req", {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, RESET_PC);

      for (int i = 0; i < 20000 && consumed <= LAST; i++) @(negedge clock);
      chk("progress", {31'h0, consumed > LAST}, 32'h1);

`ifdef FETCH_ALIGN_CHECK_EN
      repeat (5) @(negedge clock);
      #1;
      chk("fault_except", {31'h0, fetch_except}, 32'h1);
      chk("fault_req", {31'h0, imem_req}, 32'h0);
      chk("fault_valid", {31'h0, inst_valid}, 32'h0);
      chk("no_refetch", exp_addr_q.size(), 32'h0);
`else
      for (int i = 0; i < 2000 && consumed <= LAST + 2; i++) @(negedge clock);
      chk("progress_after_jr", {31'h0, consumed > LAST + 2}, 32'h1);
`endif

      // Reset while a request is outstanding, late ack right after release
      @(negedge clock);
      mon_en = 0; run = 0; mem_run = 1'b0; man_ack = 1'b0;
      repeat (6) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1 chk("wait_req", {31'h0, imem_req}, 32'h1);
      reset = 1'b0;
      @(negedge clock);
      #1;
      chk("rst_req_drop", {31'h0, imem_req}, 32'h0);
      chk("rst_except_clr", {31'h0, fetch_except}, 32'h0);
      reset = 1'b1; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
      #1;
      chk("refetch_req", {31'h0, imem_req}, 32'h1);
      chk("refetch_addr", imem_addr, RESET_PC);
      @(negedge clock);
      man_ack = 1'b0;
      #1;
      chk("late_ack_valid", {31'h0, inst_valid}, 32'h0);
      chk("late_ack_inst", inst, 32'h0);
      chk("late_ack_req", {31'h0, imem_req}, 32'h1);
      repeat (2) begin
         @(negedge clock);
         #1 chk("wait_no_valid", {31'h0, inst_valid}, 32'h0);
      end
      @(negedge clock);
      man_ack = 1'b1; man_rdata = 32'h1234_5678;
      @(negedge clock);
      man_ack = 1'b0;
      #1;
      chk("refetch_valid", {31'h0, inst_valid}, 32'h1);
      chk("refetch_inst", inst, 32'h1234_5678);
      chk("refetch_pc", inst_pc, RESET_PC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
